// File: rtl/disp_scan_dec.sv
// Binary-to-BCD converter (iterative shift-add-3) driving a multiplexed 7-segment display.
// state | meaning:  IDLE | waiting for load, display holds last result;  CONV | one bit per cycle, N cycles
module disp_scan_dec #(
  parameter int VAL_W    = 12,
  parameter int DIGITS   = 3,
  parameter int FRAC     = 1,
  parameter int SCAN_DIV = 4,
  parameter int BLANK    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [VAL_W-1:0]        value,
  input  logic                    load,
  output logic                    busy,
  output logic                    ready,
  output logic                    overflow,
  output logic [7:0]              seg,
  output logic [DIGITS+FRAC-1:0]  an
);

  localparam int N     = VAL_W - FRAC;
  // Enough BCD digits to hold any N-bit integer, so overflow is detected exactly.
  localparam int BCD_D = ((N + 2) / 3 > DIGITS) ? (N + 2) / 3 : DIGITS;
  localparam int BCD_W = 4 * BCD_D;
  localparam int NDISP = DIGITS + FRAC;
  localparam int CW    = (N > 1) ? $clog2(N) : 1;
  localparam int IW    = (NDISP > 1) ? $clog2(NDISP) : 1;
  localparam int DW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t              state, state_n;
  logic [N-1:0]        sh;
  logic [BCD_W-1:0]    bcd, adj, bcd_step;
  logic [CW-1:0]       cnt;
  logic                frac_cap;
  logic                step_ovf;
  logic                load_disp;

  logic [4*DIGITS-1:0] disp, disp_n;
  logic                disp_frac, disp_frac_n;
  logic                ovf_n;

  logic [DW-1:0]       div;
  logic                div_tc;
  logic [IW-1:0]       idx, idx_n;
  logic [7:0]          seg_n;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  always_comb begin
    adj = bcd;
    for (int i = 0; i < BCD_D; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_step = {adj[BCD_W-2:0], sh[N-1]};
    // A carry out of the top digit cannot occur with this sizing; it is folded in as a guard.
    step_ovf = adj[BCD_W-1];
    for (int i = DIGITS; i < BCD_D; i++) begin
      if (bcd_step[4*i +: 4] != 4'd0) step_ovf = 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    load_disp = 1'b0;
    case (state)
      IDLE: if (load) state_n = CONV;
      CONV: begin
        if (cnt == '0) begin
          state_n   = IDLE;
          load_disp = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == CONV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sh       <= '0;
      bcd      <= '0;
      cnt      <= '0;
      frac_cap <= 1'b0;
      ready    <= 1'b0;
    end else begin
      state <= state_n;
      ready <= load_disp;
      if (state == IDLE && load) begin
        sh       <= value[VAL_W-1:FRAC];
        frac_cap <= (FRAC != 0) && value[0];
        bcd      <= '0;
        cnt      <= CW'(N - 1);
      end else if (state == CONV) begin
        sh  <= sh << 1;
        bcd <= bcd_step;
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Next-display values feed the segment register so seg never lags a display update.
  assign disp_n      = load_disp ? bcd_step[4*DIGITS-1:0] : disp;
  assign disp_frac_n = load_disp ? frac_cap : disp_frac;
  assign ovf_n       = load_disp ? step_ovf : overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp      <= '0;
      disp_frac <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      disp      <= disp_n;
      disp_frac <= disp_frac_n;
      overflow  <= ovf_n;
    end
  end

  assign div_tc = (div == DW'(SCAN_DIV - 1));

  always_comb begin
    idx_n = idx;
    if (div_tc) idx_n = (idx == IW'(NDISP - 1)) ? '0 : idx + 1'b1;
  end

  always_comb begin
    int  j;
    logic nz;
    seg_n = 8'h00;
    j     = int'(idx_n) - FRAC;
    nz    = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (k >= j && disp_n[4*k +: 4] != 4'd0) nz = 1'b1;
    end
    if (ovf_n) begin
      seg_n = 8'h40;
    end else if (FRAC != 0 && idx_n == '0) begin
      seg_n = {1'b0, seg7(disp_frac_n ? 4'd5 : 4'd0)};
    end else begin
      if (!(BLANK != 0 && j > 0 && !nz)) seg_n[6:0] = seg7(disp_n[4*j +: 4]);
      seg_n[7] = (FRAC != 0) && (j == 0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
      idx <= '0;
      seg <= 8'h3F;
      an  <= ~NDISP'(1);
    end else begin
      div <= div_tc ? '0 : div + 1'b1;
      idx <= idx_n;
      seg <= seg_n;
      an  <= ~(NDISP'(1) << idx_n);
    end
  end

endmodule
